dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder serving the ME stage's load/store requests over a req/ack handshake with a configurable number of wait states.
- Supports word access, signed-byte load (lb), unsigned-byte load, and byte store.
- A second, read-only debug port returns the memory word selected by the board switches (in_addr) to the display path.
- Sits between the ex_mem pipeline register and mem_wb; its `busy` output stalls the pipeline while an access is outstanding.

Parameters:
- LATENCY, 2, wait-state cycles inserted between request acceptance and response (0..15).
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (1024 words = 4 KB, 12-bit byte address).

Ports:
- clk  in  1  system clock (divided pipeline clock)
- RST  in  1  synchronous reset, active-low
- req  in  1  access request from ME stage; held high until ack
- we  in  1  1 = store, 0 = load; sampled with req
- mode  in  2  00 word, 01 signed byte, 10 unsigned byte, 11 reserved (treated as word)
- addr  in  12  byte address
- wdata  in  32  store data; byte stores use wdata[7:0]
- ack  out  1  one-cycle response strobe
- rdata  out  32  load result, valid only while ack=1
- err  out  1  misaligned word access flag, valid with ack
- busy  out  1  request accepted and not yet acknowledged (pipeline stall)
- dbg_addr  in  12  switch-selected byte address (word-aligned internally)
- dbg_data  out  32  word at dbg_addr[11:2], registered

Behaviour:
- Reset (RST=0 at a clk edge): state=IDLE, ack=0, err=0, busy=0, rdata=0, dbg_data=0, wait counter=0. Memory contents are NOT cleared.
- Reset mid-operation: the pending access is abandoned and no write occurs; the requester must re-issue.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, latch addr/we/mode/wdata, set cnt=LATENCY, busy=1.
  - Next state: WAIT if LATENCY>0, else RESP.
- WAIT:
  - cnt decrements each cycle.
  - When cnt reaches 1, next state is RESP.
  - busy=1 throughout.
  - Changes on req/addr inputs are ignored, because the latched copies are used.
- RESP (exactly one cycle): perform the access, then go to IDLE.
  - Outputs: ack=1, busy=0.
  - Store, word mode: mem[a[11:2]] <= wdata.
  - Store, byte mode: only byte lane a[1:0] is replaced with wdata[7:0]; lane 0 = bits [7:0], little-endian.
  - Load, word mode: rdata = mem word.
  - Load, mode 01: rdata = sign-extended selected byte.
  - Load, mode 10: rdata = zero-extended selected byte.
  - Stores return rdata=0.
- Latency: with req high in cycle N (IDLE), ack is asserted in cycle N+1+LATENCY.
- Misaligned word access (mode 00/11 with a[1:0]!=0):
  - RESP still asserts ack, with err=1 and rdata=0.
  - A store in this case writes nothing.
- Back-to-back requests: the cycle after ack the FSM is IDLE. A req still high there is accepted as a new request, so a requester must drop req in its ack cycle if it is done. Minimum spacing between acks is LATENCY+2 cycles.
- Debug port:
  - dbg_data <= mem[dbg_addr[11:2]] every clk, so the value is visible 1 cycle after dbg_addr changes.
  - If the debug port reads a word in the same cycle RESP writes it, dbg_data shows the old value and updates on the next cycle.
- ack, err, rdata are zero in every cycle except RESP.
- The memory array is inferable as single-write / two-read (synchronous) block RAM.

Test Plan:
- Word store/load, LATENCY=2: store 0xDEADBEEF to addr 0x010, then load addr 0x010. Each ack arrives 3 cycles after req; the load returns rdata=0xDEADBEEF; busy is high for 3 cycles per access.
- Byte paths: store byte 0x80 to addr 0x013 over word 0x11223344. The word becomes 0x80223344. lb at 0x013 returns 0xFFFFFF80; unsigned byte load returns 0x00000080; lb at 0x010 returns 0x00000044.
- Misaligned: word store 0x12345678 to addr 0x022. The response is ack=1, err=1, rdata=0; a following load at 0x020 shows the old contents unchanged.
- Reset mid-operation: issue a store of 0xCAFEF00D to 0x040 and pull RST low during WAIT. No ack is seen; busy=0 after reset; a load at 0x040 returns the pre-store value.
- Back-to-back with LATENCY=0: hold req high for 4 cycles across two loads. Acks appear in cycles 1 and 3, each with correct data; no ack appears in cycle 2.
- Debug port: after storing 0x0000ABCD to 0x100, set dbg_addr=0x101. On the next cycle dbg_data=0x0000ABCD. Under a same-cycle write collision, dbg_data lags by one cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the ME stage: req/ack handshake with LATENCY wait states,
// word and byte loads/stores, and a registered read-only debug port.
module dmem_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  mode,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    input  logic [11:0] dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned AddrW = DEPTH_LOG2 + 2;
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    localparam logic [1:0] ModeSByte = 2'b01;
    localparam logic [1:0] ModeUByte = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem [Depth];
    logic [31:0] word_q;
    logic [31:0] dbg_data_q;

    logic                  is_byte;
    logic                  misaligned;
    logic [7:0]            lane;
    logic                  wr_en;
    logic [3:0]            wr_be;
    logic [31:0]           wr_word;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] dbg_idx;
    logic                  unused_dbg_lsb;

    assign unused_dbg_lsb = ^dbg_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && RST) begin
                    we_d    = we;
                    mode_d  = mode;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = LatCnt;
                    busy    = 1'b1;
                    state_d = (LATENCY > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mode_q  <= 2'b00;
            addr_q  <= 12'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Mode 11 is reserved and behaves as a word access.
    assign is_byte    = (mode_q == ModeSByte) || (mode_q == ModeUByte);
    assign misaligned = !is_byte && (addr_q[1:0] != 2'b00);

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane = word_q[7:0];
            2'd1:    lane = word_q[15:8];
            2'd2:    lane = word_q[23:16];
            default: lane = word_q[31:24];
        endcase
    end

    always_comb begin
        ack   = (state_q == StResp);
        err   = ack && misaligned;
        rdata = 32'd0;
        if (ack && !we_q && !misaligned) begin
            if (mode_q == ModeSByte) begin
                rdata = {{24{lane[7]}}, lane};
            end else if (mode_q == ModeUByte) begin
                rdata = {24'd0, lane};
            end else begin
                rdata = word_q;
            end
        end
    end

    // Byte stores replicate the byte across lanes and rely on the lane enable.
    assign wr_en   = RST && (state_q == StResp) && we_q && !misaligned;
    assign wr_be   = is_byte ? (4'b0001 << addr_q[1:0]) : 4'b1111;
    assign wr_word = is_byte ? {4{wdata_q[7:0]}} : wdata_q;

    assign wr_idx  = addr_q[AddrW-1:2];
    assign rd_idx  = addr_d[AddrW-1:2];
    assign dbg_idx = dbg_addr[AddrW-1:2];

    // The load word is fetched on the edge entering RESP, so no write can intervene.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
        word_q <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            dbg_data_q <= 32'd0;
        end else begin
            dbg_data_q <= mem[dbg_idx];
        end
    end

    assign dbg_data = dbg_data_q;

endmodule
